// File: rtl/tm1638_pkg.sv
// Shared types and protocol constants for the TM1638 responder model.
// Command classes live in byte[7:6]; data-command flags are bit positions.
package tm1638_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE
    } state_t;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int READ      = 1;
    localparam int FIXED     = 2;
    localparam int KEY_BYTES = 4;

endpackage

// File: rtl/tm1638_pin_sync.sv
// Multi-flop synchronizer for one serial pin, followed by a delay flop and
// registered one-cycle rise/fall pulses aligned with the delayed level.
module tm1638_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   dly_reg;
    logic                   rise_reg;
    logic                   fall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= {SYNC_STAGES{IDLE_LEVEL}};
            dly_reg  <= IDLE_LEVEL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
            dly_reg  <= sync_reg[SYNC_STAGES-1];
            // Pulses land together with dly_reg so sampled data lines up with the edge.
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~dly_reg;
            fall_reg <= ~sync_reg[SYNC_STAGES-1] & dly_reg;
        end
    end

    assign level = dly_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device emulator: decodes STB/CLK/DIO frames into display RAM writes,
// display-control state and a 32-bit key-scan readback shifted out on DIO.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              stb_in,
    input  logic              clk_in,
    input  logic              dio_in,
    output logic              dio_out,
    output logic              dio_oe,
    input  logic [31:0]       key_data,
    output logic              key_read,
    input  logic [ADDR_W-1:0] disp_raddr,
    output logic [7:0]        disp_rdata,
    output logic              disp_on,
    output logic [2:0]        brightness,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              proto_err
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [5:0] KEY_BITS = 6'(KEY_BYTES * 8);

    logic stb_rise, stb_fall, sclk_rise, sclk_fall, dio_lvl;
    logic unused_stb_lvl, unused_sclk_lvl, unused_dio_rise, unused_dio_fall;

    tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_stb_sync (
        .clk   (CLK),
        .rst_n (nRST),
        .pin   (stb_in),
        .level (unused_stb_lvl),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_clk_sync (
        .clk   (CLK),
        .rst_n (nRST),
        .pin   (clk_in),
        .level (unused_sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_dio_sync (
        .clk   (CLK),
        .rst_n (nRST),
        .pin   (dio_in),
        .level (dio_lvl),
        .rise  (unused_dio_rise),
        .fall  (unused_dio_fall)
    );

    state_t            state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        byte_sr_reg;
    logic [5:0]        rd_bits_reg;
    logic              rd_pend_reg;
    logic [31:0]       key_sr_reg;
    logic              fixed_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic [7:0] full_byte;
    logic       byte_done;
    logic       ram_we;
    logic [7:0] ram [DEPTH];

    // Byte as it stands once the bit arriving with this rising edge is included.
    assign full_byte = {dio_lvl, byte_sr_reg[7:1]};
    assign byte_done = sclk_rise && !stb_rise && (bit_cnt_reg == 3'd7);
    assign ram_we    = byte_done && (state_reg == ST_WR_DATA);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ram
        logic [7:0] row_reg;

        always_ff @(posedge CLK) begin
            if (!nRST) begin
                row_reg <= 8'h00;
            end else if (ram_we && (addr_reg == ADDR_W'(gi))) begin
                row_reg <= full_byte;
            end
        end

        assign ram[gi] = row_reg;
    end

    assign disp_rdata = ram[disp_raddr];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            byte_sr_reg <= 8'h00;
            rd_bits_reg <= 6'd0;
            rd_pend_reg <= 1'b0;
            key_sr_reg  <= 32'h0;
            fixed_reg   <= 1'b0;
            addr_reg    <= '0;
            disp_on     <= 1'b0;
            brightness  <= 3'd0;
            dio_oe      <= 1'b0;
            dio_out     <= 1'b0;
            key_read    <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'h00;
            frame_done  <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            key_read   <= 1'b0;
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;

            if (stb_rise) begin
                // STB release outranks any clock edge seen in the same cycle.
                state_reg   <= ST_IDLE;
                dio_oe      <= 1'b0;
                frame_done  <= 1'b1;
                bit_cnt_reg <= 3'd0;
                if ((state_reg == ST_CMD || state_reg == ST_WR_DATA ||
                     state_reg == ST_RD_DATA) && bit_cnt_reg != 3'd0) begin
                    proto_err <= 1'b1;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (stb_fall) begin
                            state_reg   <= ST_CMD;
                            bit_cnt_reg <= 3'd0;
                        end
                    end

                    ST_CMD: begin
                        if (sclk_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            byte_sr_reg <= full_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                unique case (full_byte[7:6])
                                    CMD_DATA: begin
                                        fixed_reg <= full_byte[FIXED];
                                        if (full_byte[READ:0] == 2'b10) begin
                                            state_reg   <= ST_RD_DATA;
                                            key_sr_reg  <= key_data;
                                            key_read    <= 1'b1;
                                            dio_oe      <= 1'b1;
                                            dio_out     <= key_data[0];
                                            rd_bits_reg <= 6'd0;
                                            rd_pend_reg <= 1'b0;
                                        end else begin
                                            state_reg <= ST_IGNORE;
                                            proto_err <= (full_byte[READ:0] != 2'b00);
                                        end
                                    end
                                    CMD_CTRL: begin
                                        disp_on    <= full_byte[3];
                                        brightness <= full_byte[2:0];
                                        state_reg  <= ST_IGNORE;
                                    end
                                    CMD_ADDR: begin
                                        addr_reg  <= full_byte[ADDR_W-1:0];
                                        state_reg <= ST_WR_DATA;
                                    end
                                    default: begin
                                        proto_err <= 1'b1;
                                        state_reg <= ST_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (sclk_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            byte_sr_reg <= full_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr_reg;
                                wr_data   <= full_byte;
                                if (!fixed_reg) begin
                                    addr_reg <= addr_reg + ADDR_W'(1);
                                end
                            end
                        end
                    end

                    ST_RD_DATA: begin
                        // Shift only on a falling edge that closes a counted bit.
                        if (sclk_rise && rd_bits_reg < KEY_BITS) begin
                            rd_bits_reg <= rd_bits_reg + 6'd1;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            rd_pend_reg <= 1'b1;
                        end else if (sclk_fall && rd_pend_reg) begin
                            rd_pend_reg <= 1'b0;
                            key_sr_reg  <= key_sr_reg >> 1;
                            dio_out     <= key_sr_reg[1];
                            if (rd_bits_reg == KEY_BITS) begin
                                dio_oe <= 1'b0;
                            end
                        end
                    end

                    ST_IGNORE: begin
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tm1638_responder.md
# tm1638_responder

Cycle-accurate TM1638 device emulator: the responder end of the STB/CLK/DIO link that `TM1638_board_interface_ex` drives. It oversamples the three serial pins in the `CLK` (16 MHz) domain and decodes command frames. It holds the 16-byte display RAM plus display-control state, and shifts out a 32-bit key-scan word on read frames. It serves as a bench-side device model and as an on-board loopback target for bring-up, without a physical TM1638 module.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per input pin, minimum 2.
- `ADDR_W`, 4: display RAM address width; depth is 2**ADDR_W.
- `CLK` in 1: master clock, 16 MHz.
- `nRST` in 1: reset, synchronous, active-low.
- `stb_in` in 1: STB from initiator, active-low frame enable.
- `clk_in` in 1: serial clock from initiator.
- `dio_in` in 1: DIO as seen at the pad.
- `dio_out` out 1: DIO drive value.
- `dio_oe` out 1: DIO output enable; 1 = responder drives the pad.
- `key_data` in 32: key-scan word, snapshotted at read start.
- `key_read` out 1: one-cycle pulse when `key_data` is snapshotted.
- `disp_raddr` in ADDR_W: display RAM read address.
- `disp_rdata` out 8: RAM byte at `disp_raddr`, combinational read.
- `disp_on` out 1: display enable from the last control command.
- `brightness` out 3: brightness from the last control command.
- `wr_strobe` out 1: one-cycle pulse per RAM byte written.
- `wr_addr` out ADDR_W: address of the write; valid with `wr_strobe`.
- `wr_data` out 8: byte written; valid with `wr_strobe`.
- `frame_done` out 1: one-cycle pulse on each STB rising edge.
- `proto_err` out 1: one-cycle pulse on frame abort or invalid command.

## Operation
- **Input conditioning**
  - Each pin passes through SYNC_STAGES flops, then one delay flop.
  - Edges are derived in the `CLK` domain.
  - Bits are sampled on synchronized `clk_in` rising edges, LSB first.
  - A bit counter (0–7) assembles bytes.
- **States:** IDLE, CMD, WR_DATA, RD_DATA, IGNORE.
  - IDLE → CMD on `stb_in` falling edge; clear the bit counter.
  - CMD, 8th bit: decode by byte[7:6].
    - 01, data command: latch `fixed = b[2]`.
      - b[1:0] = 10 → RD_DATA.
      - b[1:0] = 00 → IGNORE.
      - Other b[1:0] values → IGNORE plus `proto_err`.
    - 10, display control: `disp_on <= b[3]`, `brightness <= b[2:0]`; → IGNORE.
    - 11, address command: `addr <= b[ADDR_W-1:0]`; → WR_DATA.
    - 00: `proto_err`; → IGNORE.
  - WR_DATA, each 8th bit:
    - Write RAM[addr] and pulse `wr_strobe` with that addr/data.
    - If `fixed` = 0, addr increments and wraps 0xF → 0x0.
  - RD_DATA:
    - On entry, load a 32-bit shift register from `key_data`, pulse `key_read`, and set `dio_oe` = 1 with `dio_out` = sr[0].
    - On each `clk_in` falling edge that follows a counted rising edge, shift right.
    - After the falling edge that follows the 32nd rising edge, `dio_oe` = 0; further clocks are ignored.
  - Any state, on `stb_in` rising edge: → IDLE, `dio_oe` = 0, pulse `frame_done`.
  - If that edge arrives with a partial byte (bit counter ≠ 0) in CMD, WR_DATA or RD_DATA:
    - Discard the partial byte and pulse `proto_err`.
    - Exception: RD_DATA after all 32 bits is not an error.
- **Persistence:** `fixed`, `addr`, `disp_on`, `brightness` and RAM persist across frames.
- **Reset** (`nRST` = 0 at a `CLK` edge, including mid-frame):
  - State → IDLE; RAM cleared to 0x00; `addr` = 0; `fixed` = 0.
  - `disp_on` = 0; `brightness` = 0; `dio_oe` = 0; `dio_out` = 0.
  - All pulse outputs = 0; synchronizers flushed to idle levels (stb = 1, clk = 1).

## Timing
- Pin-to-edge recognition latency is SYNC_STAGES+1 `CLK` cycles (3 at default).
- Initiator requirements:
  - `clk_in` high and low phases each ≥ 4 `CLK` cycles.
  - ≥ 6 `CLK` cycles from the last command-byte rising edge to the first read rising edge.
- `dio_out` updates SYNC_STAGES+2 cycles after the `clk_in` falling pin edge.
- `dio_oe` rises SYNC_STAGES+2 cycles after the 8th command rising pin edge.
- Timing of RAM writes:
  - `wr_strobe` asserts the cycle after the 8th rising edge is recognized.
  - RAM and `disp_rdata` update on that same edge.
- `disp_on`/`brightness` update the cycle after the control byte completes.
- Simultaneous `clk_in` edge and `stb_in` rising edge in one cycle: STB wins; the clock edge is discarded.

## Structure
- `tm1638_pkg`:
  - State enum.
  - Command-class constants: CMD_DATA = 2'b01, CMD_CTRL = 2'b10, CMD_ADDR = 2'b11.
  - Data-command bit positions: READ = 1, FIXED = 2.
  - KEY_BYTES = 4.
- Sub-module `tm1638_pin_sync`: parameterized synchronizer plus rise/fall detect per pin, instantiated three times.
- RAM is a flop array, which allows reset clearing and combinational read.

## Test plan
- **Auto-increment write:** frame 0x40; frame 0xC0, 0x3F, 0x06, 0x5B → RAM[0..2] = 3F/06/5B, three `wr_strobe` pulses at addr 0, 1, 2, `proto_err` = 0.
- **Fixed-address write with wrap:** frame 0x44; frame 0xCF, 0xAA, 0x55 → RAM[F] = 0x55, RAM[0] untouched. Then frame 0x40; frame 0xCF, 0x11, 0x22 → RAM[F] = 0x11, RAM[0] = 0x22.
- **Display control:** frame 0x8A → `disp_on` = 1, `brightness` = 2. Frame 0x80 → `disp_on` = 0, `brightness` = 0.
- **Key read:** `key_data` = 0x8001_A55A; frame 0x42 plus 32 clocks → initiator samples bytes 5A, A5, 01, 80; one `key_read` pulse; `dio_oe` = 0 after the 32nd falling edge.
- **Abort:** STB raised after 5 bits of the second data byte → only the first byte is written, `proto_err` pulses once, `frame_done` pulses once, `dio_oe` = 0.
- **Reset mid-read:** `nRST` low for 1 cycle during bit 12 of a read → `dio_oe` = 0 the next cycle, RAM all 0x00, and the next 0x40/0xC0 frame writes normally.
